// File: rtl/timer_pkg.sv
// Shared definitions for the microwave timer input stage: key widths,
// keypad FSM encoding and the one-hot keypad decoder.
package timer_pkg;

    localparam int BCD_W = 4;
    localparam int NKEYS = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_LOAD,
        ST_WAIT_RELEASE
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             multi;
        logic [BCD_W-1:0] code;
    } key_t;

    // Exactly one bit set gives its index; zero or several bits give code 0.
    function automatic key_t onehot_to_bcd(input logic [NKEYS-1:0] keys);
        key_t r;
        int   n;
        r = '0;
        n = 0;
        for (int i = 0; i < NKEYS; i++) begin
            if (keys[i]) begin
                n++;
                r.code = BCD_W'(i);
            end
        end
        r.valid = (n == 1);
        r.multi = (n > 1);
        if (!r.valid) r.code = '0;
        return r;
    endfunction

endpackage

// File: rtl/clock_divider.sv
// Free-running divider producing a 50% duty square wave of CLK_DIV cycles.
module clock_divider #(
    parameter int CLK_DIV = 100
) (
    input  logic clock,
    input  logic clearn,
    output logic pgt_1Hz
);

    localparam int W = $clog2(CLK_DIV);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            r_cnt   <= '0;
            pgt_1Hz <= 1'b0;
        end else begin
            if (r_cnt == W'(CLK_DIV - 1)) r_cnt <= '0;
            else                          r_cnt <= r_cnt + 1'b1;
            if (r_cnt == W'(CLK_DIV / 2 - 1) || r_cnt == W'(CLK_DIV - 1))
                pgt_1Hz <= ~pgt_1Hz;
        end
    end

endmodule

// File: rtl/timer_keypad_entry.sv
// Keypad front end: debounces the one-hot keypad, shifts accepted BCD digits
// into the entry register with a one-cycle loadn strobe, and divides the 1Hz tick.
module timer_keypad_entry
    import timer_pkg::*;
#(
    parameter int NDIGITS  = 4,
    parameter int DEBOUNCE = 4,
    parameter int CLK_DIV  = 100
) (
    input  logic                           clock,
    input  logic                           clearn,
    input  logic [NKEYS-1:0]               teclado,
    input  logic                           enablen,
    input  logic                           clear_entry,
    output logic [BCD_W-1:0]               D,
    output logic                           loadn,
    output logic [BCD_W*NDIGITS-1:0]       digits,
    output logic [$clog2(NDIGITS+1)-1:0]   count,
    output logic                           key_err,
    output logic                           pgt_1Hz
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam int CW    = $clog2(NDIGITS + 1);
    localparam int DW    = BCD_W * NDIGITS;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [BCD_W-1:0] r_code;

    key_t             w_key;
    logic             w_load;
    logic [DW-1:0]    w_shifted;
    logic [CW-1:0]    w_count_next;

    assign w_key        = onehot_to_bcd(teclado);
    assign w_count_next = (count == CW'(NDIGITS)) ? count : count + 1'b1;

    // A load fires on the edge that completes the debounce run.
    assign w_load = !enablen && w_key.valid &&
                    ((r_state == ST_IDLE && DEBOUNCE == 1) ||
                     (r_state == ST_DEBOUNCE && w_key.code == r_code &&
                      r_cnt == CNT_W'(DEBOUNCE - 1)));

    always_comb begin
        w_shifted = '0;
        w_shifted[BCD_W-1:0] = w_key.code;
        for (int i = 1; i < NDIGITS; i++)
            w_shifted[i*BCD_W +: BCD_W] = digits[(i-1)*BCD_W +: BCD_W];
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_code  <= '0;
            D       <= '0;
            loadn   <= 1'b1;
            digits  <= '0;
            count   <= '0;
            key_err <= 1'b0;
        end else begin
            loadn   <= 1'b1;
            key_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!enablen) begin
                        if (w_key.valid) begin
                            r_state <= w_load ? ST_LOAD : ST_DEBOUNCE;
                            r_cnt   <= CNT_W'(1);
                            r_code  <= w_key.code;
                        end else if (w_key.multi) begin
                            key_err <= 1'b1;
                            r_state <= ST_WAIT_RELEASE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (enablen) begin
                        r_state <= ST_IDLE;
                    end else if (w_key.multi) begin
                        key_err <= 1'b1;
                        r_state <= ST_WAIT_RELEASE;
                    end else if (!w_key.valid) begin
                        r_state <= ST_IDLE;
                    end else if (w_key.code == r_code) begin
                        if (w_load) r_state <= ST_LOAD;
                        else        r_cnt   <= r_cnt + 1'b1;
                    end else begin
                        r_cnt  <= CNT_W'(1);
                        r_code <= w_key.code;
                    end
                end
                ST_LOAD: r_state <= ST_WAIT_RELEASE;
                ST_WAIT_RELEASE: begin
                    if (teclado == '0) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_load) begin
                loadn <= 1'b0;
                D     <= w_key.code;
            end
            // A clear wins over a same-cycle load; the strobe and D still go out.
            if (clear_entry) begin
                digits <= '0;
                count  <= '0;
            end else if (w_load) begin
                digits <= w_shifted;
                count  <= w_count_next;
            end
        end
    end

    clock_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clock   (clock),
        .clearn  (clearn),
        .pgt_1Hz (pgt_1Hz)
    );

endmodule
